// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle subtractor o = a - b, one 4-bit nibble per clock, LSB first.
// The borrow ripples between nibbles through a registered carry (carry = ~borrow).
// Optional feature macro: NIBBLE_SUB_OVF_EN drives v with the signed overflow of a - b;
// without it v is tied to 0.
module nibble_serial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             borrow,
    output logic             zero,
    output logic             v
);

    localparam int unsigned STEPS  = WIDTH / 4;
    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : gen_width_check
        $error("nibble_serial_sub: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    o_q, o_d;
    logic                carry_q, carry_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                borrow_q, borrow_d;
    logic                zero_q, zero_d;

    logic [3:0]          a_nib, b_nib;
    logic [4:0]          sum5;
    logic                last_step;

    // Current nibble of the operands and its sum with the inverted subtrahend plus carry.
    always_comb begin
        a_nib     = a_q[4*int'(step_q) +: 4];
        b_nib     = b_q[4*int'(step_q) +: 4];
        sum5      = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
        last_step = (step_q == STEP_W'(STEPS - 1));
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        o_d      = o_q;
        carry_d  = carry_q;
        step_d   = step_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    step_d  = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Nibbles are written in place; o is only meaningful with out_valid.
                o_d[4*int'(step_q) +: 4] = sum5[3:0];
                carry_d                  = sum5[4];
                if (last_step) begin
                    step_d   = '0;
                    borrow_d = ~sum5[4];
                    zero_d   = (o_d == '0);
                    state_d  = StDone;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; a reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            o_q      <= '0;
            carry_q  <= 1'b1;
            step_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            o_q      <= o_d;
            carry_q  <= carry_d;
            step_q   <= step_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

`ifdef NIBBLE_SUB_OVF_EN
    logic v_q;

    // Signed overflow: operand signs differ and the result sign differs from the minuend.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
        end else if ((state_q == StBusy) && last_step) begin
            v_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sum5[3]);
        end
    end

    assign v = v_q;
`else
    assign v = 1'b0;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign o         = o_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule
